// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS front end.
//                fetch_state_t  - fetch FSM state encoding
//                OP_*           - primary opcode values seen on instr[31:26]
//                RESET_PC_DEFAULT - default reset program counter
//                align_word()   - clears the byte-offset bits of an address
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Misaligned targets are silently truncated to a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch stage's bus signals.
//                imem_*        - req/ack instruction memory port
//                instr_*, op, funct, pc, pcplus4 - downstream handshake/data
//                jump*, branch_* - redirect inputs from decoder/datapath
//                modport master : the fetch unit
//                modport slave  : memory + downstream environment
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, op, funct, pc, pcplus4,
    input  instr_ready,
    input  jump, jump_target, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, op, funct, pc, pcplus4,
    output instr_ready,
    output jump, jump_target, branch_taken, branch_target
  );

endinterface
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_mux
//  Description : Next-PC selection. Jump beats branch beats sequential, and
//                the result is forced to a word boundary.
//                i_pcplus4, i_jump_target, i_branch_target : candidates
//                i_jump, i_branch_taken                    : selects
//                o_next_pc                                 : aligned next PC
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [31:0] i_pcplus4,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic        i_branch_taken,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_sel;

  always_comb begin
    w_sel = i_pcplus4;
    if (i_jump) begin
      w_sel = i_jump_target;
    end else if (i_branch_taken) begin
      w_sel = i_branch_target;
    end
    o_next_pc = align_word(w_sel);
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Holds the PC, fetches one word at a
//                time over a req/ack port, keeps it in the instruction
//                register until downstream retires it, then advances the PC.
//                clk     - rising-edge clock
//                reset   - asynchronous, active-high
//                bus     - fetch_unit_if.master (imem port, downstream port,
//                          redirect inputs)
//                retired - wrapping count of retired instructions
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     bus,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] c_ST_IDLE = IDLE;
  localparam logic [1:0] c_ST_REQ  = REQ;
  localparam logic [1:0] c_ST_HOLD = HOLD;

  logic [1:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired;

  logic [31:0] w_pcplus4;
  logic [31:0] w_next_pc;
  logic        w_retire;

  assign w_pcplus4 = r_pc + 32'd4;
  assign w_retire  = (r_state == c_ST_HOLD) && bus.instr_ready;

  pc_next_mux u_pc_next_mux (
    .i_pcplus4       (w_pcplus4),
    .i_jump_target   (bus.jump_target),
    .i_branch_target (bus.branch_target),
    .i_jump          (bus.jump),
    .i_branch_taken  (bus.branch_taken),
    .o_next_pc       (w_next_pc)
  );

  // The redirect inputs only matter on the retiring edge; everywhere else the
  // mux output is simply not consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_ST_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_retired <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          r_state <= c_ST_REQ;
        end
        c_ST_REQ: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_state <= c_ST_HOLD;
          end
        end
        c_ST_HOLD: begin
          if (w_retire) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= c_ST_REQ;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // drops imem_req without waiting for a clock edge.
  assign bus.imem_req    = (r_state == c_ST_REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == c_ST_HOLD);
  assign bus.instr       = r_instr;
  assign bus.op          = r_instr[31:26];
  assign bus.funct       = r_instr[5:0];
  assign bus.pc          = r_pc;
  assign bus.pcplus4     = w_pcplus4;
  assign retired         = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Two instances: one at
//                the default reset PC with a full-width counter, one at
//                RESET_PC=0xFFFF_FFFC with a 2-bit counter for wrap cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic        r_ack, r_ready, r_jmp, r_btk;
  logic [31:0] r_rdata, r_jt, r_bt;
  logic [31:0] ret0;
  logic [1:0]  ret1;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .retired(ret0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1), .retired(ret1));

  assign bus0.imem_ack = r_ack;           assign bus1.imem_ack = r_ack;
  assign bus0.imem_rdata = r_rdata;       assign bus1.imem_rdata = r_rdata;
  assign bus0.instr_ready = r_ready;      assign bus1.instr_ready = r_ready;
  assign bus0.jump = r_jmp;               assign bus1.jump = r_jmp;
  assign bus0.jump_target = r_jt;         assign bus1.jump_target = r_jt;
  assign bus0.branch_taken = r_btk;       assign bus1.branch_taken = r_btk;
  assign bus0.branch_target = r_bt;       assign bus1.branch_target = r_bt;

  // Observation of whichever instance is under test.
  int u = 0;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pcp4, w_ret;
  logic [5:0]  w_op, w_funct;
  assign w_req   = (u == 1) ? bus1.imem_req    : bus0.imem_req;
  assign w_valid = (u == 1) ? bus1.instr_valid : bus0.instr_valid;
  assign w_addr  = (u == 1) ? bus1.imem_addr   : bus0.imem_addr;
  assign w_instr = (u == 1) ? bus1.instr       : bus0.instr;
  assign w_pc    = (u == 1) ? bus1.pc          : bus0.pc;
  assign w_pcp4  = (u == 1) ? bus1.pcplus4     : bus0.pcplus4;
  assign w_op    = (u == 1) ? bus1.op          : bus0.op;
  assign w_funct = (u == 1) ? bus1.funct       : bus0.funct;
  assign w_ret   = (u == 1) ? {30'd0, ret1}    : ret0;

  // Reference model: architectural PC, retire count and latched word.
  logic [31:0] m_pc, m_ret, m_mask, m_instr;
  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag);
    chk({tag, ".req"},   {31'd0, w_req},   32'd1);
    chk({tag, ".valid"}, {31'd0, w_valid}, 32'd0);
    chk({tag, ".addr"},  w_addr, m_pc);
    chk({tag, ".ret"},   w_ret,  m_ret);
  endtask

  task automatic check_hold(input string tag);
    chk({tag, ".valid"}, {31'd0, w_valid}, 32'd1);
    chk({tag, ".req"},   {31'd0, w_req},   32'd0);
    chk({tag, ".instr"}, w_instr, m_instr);
    chk({tag, ".op"},    {26'd0, w_op},    {26'd0, m_instr[31:26]});
    chk({tag, ".funct"}, {26'd0, w_funct}, {26'd0, m_instr[5:0]});
    chk({tag, ".pc"},    w_pc,   m_pc);
    chk({tag, ".pcp4"},  w_pcp4, m_pc + 32'd4);
  endtask

  // Enter in REQ; ack after 'delay' idle REQ cycles; leave in HOLD.
  task automatic do_fetch(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      r_ack = 1'b0;
      r_rdata = $urandom;
      check_req("fetch_wait");
      step();
    end
    r_ack = 1'b1;
    r_rdata = word;
    check_req("fetch_ack");
    step();
    r_ack = 1'b0;
    r_rdata = $urandom;
    m_instr = word;
    check_hold("hold");
  endtask

  // Enter in HOLD; keep ready low for 'wcyc' cycles with noise on ack and
  // redirect inputs, then retire with the given redirect; leave in REQ.
  task automatic do_retire(input int wcyc, input logic j, input logic [31:0] jtv,
                           input logic b, input logic [31:0] btv);
    logic [31:0] nxt;
    for (int i = 0; i < wcyc; i++) begin
      r_ready = 1'b0;
      r_ack = 1'($urandom_range(0, 1));
      r_rdata = $urandom;
      r_jmp = 1'($urandom_range(0, 1));
      r_btk = 1'($urandom_range(0, 1));
      r_jt = $urandom;
      r_bt = $urandom;
      step();
      check_hold("hold_wait");
    end
    r_ready = 1'b1;
    r_jmp = j; r_jt = jtv; r_btk = b; r_bt = btv;
    step();
    r_ready = 1'b0; r_ack = 1'b0; r_jmp = 1'b0; r_btk = 1'b0;
    r_jt = $urandom; r_bt = $urandom;
    if (j) nxt = jtv;
    else if (b) nxt = btv;
    else nxt = m_pc + 32'd4;
    m_pc = {nxt[31:2], 2'b00};
    m_ret = (m_ret + 32'd1) & m_mask;
    check_req("retire");
  endtask

  initial begin
    logic [31:0] a;
    r_ack = 1'b0; r_ready = 1'b0; r_jmp = 1'b0; r_btk = 1'b0;
    r_rdata = 32'd0; r_jt = 32'd0; r_bt = 32'd0;
    rst0 = 1'b1; rst1 = 1'b1;
    m_pc = 32'd0; m_ret = 32'd0; m_mask = 32'hFFFF_FFFF; m_instr = 32'd0;
    step(); step();

    // Reset state
    chk("rst.req",   {31'd0, w_req},   32'd0);
    chk("rst.valid", {31'd0, w_valid}, 32'd0);
    chk("rst.pc",    w_pc,    32'd0);
    chk("rst.instr", w_instr, 32'd0);
    chk("rst.ret",   w_ret,   32'd0);

    // 1: release, ack already high; IDLE bubble then REQ then HOLD
    rst0 = 1'b0;
    r_ack = 1'b1; r_rdata = 32'h2008_0005;
    chk("t1.idle_req", {31'd0, w_req}, 32'd0);
    step();
    check_req("t1.req");
    step();
    r_ack = 1'b0;
    m_instr = 32'h2008_0005;
    check_hold("t1.hold");
    chk("t1.op",   {26'd0, w_op}, 32'd8);
    chk("t1.pcp4", w_pcp4, 32'd4);
    do_retire(0, 1'b0, 32'd0, 1'b0, 32'd0);

    // 2: back-to-back, sequential addresses
    for (int k = 0; k < 3; k++) begin
      do_fetch(0, $urandom);
      do_retire(0, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    chk("t2.addr", w_addr, 32'h10);
    chk("t2.ret",  w_ret,  32'd4);

    // 3: slow ack, slow ready, spurious acks in HOLD
    do_fetch(3, 32'h8C22_0010);
    do_retire(5, 1'b0, 32'd0, 1'b0, 32'd0);

    // 4: redirects
    do_fetch(0, 32'h1000_000F);
    do_retire(0, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0040);
    chk("t4.branch", w_addr, 32'h40);
    do_fetch(1, 32'h0800_0040);
    do_retire(0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0300);
    chk("t4.jump_prio", w_addr, 32'h100);
    do_fetch(0, 32'h0800_0040);
    do_retire(2, 1'b1, 32'h0000_0103, 1'b0, 32'd0);
    chk("t4.align", w_addr, 32'h100);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int sel;
      do_fetch(int'($urandom_range(0, 3)), $urandom);
      sel = int'($urandom_range(0, 3));
      do_retire(int'($urandom_range(0, 3)), sel == 0, $urandom, sel <= 1, $urandom);
    end

    // 6: reset between edges while in REQ
    r_ack = 1'b0;
    check_req("t6.pre");
    step();
    rst0 = 1'b1;
    r_ack = 1'b1;
    #1;
    m_pc = 32'd0; m_ret = 32'd0;
    chk("t6.req_drop", {31'd0, w_req},   32'd0);
    chk("t6.valid",    {31'd0, w_valid}, 32'd0);
    chk("t6.pc",       w_pc,  32'd0);
    chk("t6.ret",      w_ret, 32'd0);
    step();
    chk("t6.held_req", {31'd0, w_req}, 32'd0);
    rst0 = 1'b0;
    r_ack = 1'b0;
    chk("t6.idle_req", {31'd0, w_req}, 32'd0);
    step();
    check_req("t6.restart");
    do_fetch(0, 32'h0000_0020);
    do_retire(0, 1'b0, 32'd0, 1'b0, 32'd0);

    // 5: top-of-memory reset PC and 2-bit counter wrap on the second instance
    rst0 = 1'b1;
    u = 1;
    m_pc = 32'hFFFF_FFFC; m_ret = 32'd0; m_mask = 32'd3;
    #1;
    chk("t5.rst_pc",   w_pc,   32'hFFFF_FFFC);
    chk("t5.rst_pcp4", w_pcp4, 32'd0);
    rst1 = 1'b0;
    chk("t5.idle_req", {31'd0, w_req}, 32'd0);
    step();
    check_req("t5.req");
    do_fetch(0, 32'h0000_0020);
    do_retire(0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t5.wrap_addr", w_addr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      do_fetch(0, a);
      do_retire(1, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    chk("t5.ret_wrap", w_ret, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
